// File: rtl/lfsr_range_rng.sv
// Free-running Fibonacci LFSR with seed load, lockup recovery and a
// req/valid interface that returns values uniformly drawn from [0, limit).
module lfsr_range_rng #(
    parameter int             N            = 16,
    parameter int             BITS         = 4,
    parameter logic [N-1:0]   TAPS         = 16'hB400,
    parameter logic [N-1:0]   SEED_DEFAULT = {{(N-1){1'b0}}, 1'b1},
    parameter int             MAX_TRIES    = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seed_load,
    input  logic [N-1:0]    seed,
    input  logic [BITS-1:0] limit,
    input  logic            req,
    output logic [BITS-1:0] random,
    output logic            valid,
    output logic            err,
    output logic            busy
);

    localparam int           TW       = $clog2(MAX_TRIES + 1);
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] SEED_RST = (SEED_DEFAULT == '0) ? ONE : SEED_DEFAULT;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    lfsr;
    logic [N-1:0]    lfsr_next;
    logic            fb;
    logic [BITS-1:0] cand;
    logic [BITS:0]   eff_limit;
    logic            accept;
    logic [TW-1:0]   tries;
    logic [TW-1:0]   tries_next;
    logic [BITS-1:0] random_next;
    logic            valid_next;
    logic            err_next;

    // An all-zero register would stick forever, so it is forced back to 1.
    always_comb begin
        fb        = ^(lfsr & TAPS);
        lfsr_next = (lfsr == '0) ? ONE : {lfsr[N-2:0], fb};
    end

    // limit=0 stands for the full 2^BITS range, hence the extra bit.
    always_comb begin
        cand      = lfsr[BITS-1:0];
        eff_limit = (limit == '0) ? {1'b1, {BITS{1'b0}}} : {1'b0, limit};
        accept    = ({1'b0, cand} < eff_limit);
    end

    always_comb begin
        state_next  = state;
        tries_next  = tries;
        random_next = random;
        valid_next  = 1'b0;
        err_next    = err;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_next = SEARCH;
                    tries_next = '0;
                    err_next   = 1'b0;
                end
            end
            SEARCH: begin
                if (accept) begin
                    random_next = cand;
                    valid_next  = 1'b1;
                    err_next    = 1'b0;
                    state_next  = IDLE;
                end else begin
                    tries_next = tries + TW'(1);
                    if (tries == TW'(MAX_TRIES - 1)) begin
                        random_next = '0;
                        valid_next  = 1'b1;
                        err_next    = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A seed load aborts any search silently and skips the LFSR step.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr   <= SEED_RST;
            state  <= IDLE;
            tries  <= '0;
            random <= '0;
            valid  <= 1'b0;
            err    <= 1'b0;
        end else if (seed_load) begin
            lfsr  <= (seed == '0) ? ONE : seed;
            state <= IDLE;
            tries <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            lfsr   <= lfsr_next;
            state  <= state_next;
            tries  <= tries_next;
            random <= random_next;
            valid  <= valid_next;
            err    <= err_next;
        end
    end

    assign busy = (state == SEARCH);

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Directed bench for lfsr_range_rng: two instances (generous and tight
// retry budgets) share stimulus; results are checked through scoreboards.
module tb_lfsr_range_rng;

    logic       clk = 1'b0;
    logic       rst;
    logic       seed_load;
    logic [3:0] seed;
    logic [3:0] limit;
    logic       req;

    logic [3:0] random_a, random_b;
    logic       valid_a, valid_b;
    logic       err_a, err_b;
    logic       busy_a, busy_b;

    always #5 clk = ~clk;

    lfsr_range_rng #(
        .N(4), .BITS(4), .TAPS(4'b1001), .SEED_DEFAULT(4'd1), .MAX_TRIES(64)
    ) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .limit(limit),
        .req(req), .random(random_a), .valid(valid_a), .err(err_a), .busy(busy_a)
    );

    lfsr_range_rng #(
        .N(4), .BITS(4), .TAPS(4'b1001), .SEED_DEFAULT(4'd0), .MAX_TRIES(4)
    ) dut_err (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .limit(limit),
        .req(req), .random(random_b), .valid(valid_b), .err(err_b), .busy(busy_b)
    );

    typedef struct packed {
        logic [3:0] value;
        logic       err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] period_seq [16] = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5,
                                    4'd11, 4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8, 4'd1};
    logic [3:0] mlfsr;
    exp_t       e;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic sl, input logic [3:0] sd, input logic rq,
                                 input logic [3:0] lim);
        seed_load = sl;
        seed      = sd;
        req       = rq;
        limit     = lim;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] stepModel(input logic [3:0] x);
        if (x == 4'd0) return 4'd1;
        return {x[2:0], x[3] ^ x[0]};
    endfunction

    task automatic popCheckA();
        checkOutput("q_a_nonempty", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            checkOutput("random_a", 32'(random_a), 32'(e.value));
            checkOutput("err_a", 32'(err_a), 32'(e.err));
        end
    endtask

    task automatic popCheckB();
        checkOutput("q_b_nonempty", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            checkOutput("random_b", 32'(random_b), 32'(e.value));
            checkOutput("err_b", 32'(err_b), 32'(e.err));
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd3);
        tick();
        checkOutput("rst_random", 32'(random_a), 32'd0);
        checkOutput("rst_valid", 32'(valid_a), 32'd0);
        checkOutput("rst_err", 32'(err_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_lfsr", 32'(dut.lfsr), 32'd1);
        checkOutput("rst_lfsr_seed0", 32'(dut_err.lfsr), 32'd1);
        checkOutput("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;

        // Period check from seed 1
        applyStimulus(1'b1, 4'd1, 1'b0, 4'd3);
        tick();
        applyStimulus(1'b0, 4'd1, 1'b0, 4'd3);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("period[%0d]", i), 32'(dut.lfsr), 32'(period_seq[i]));
            tick();
        end

        // Seed 0 loads 1; this edge is e0 of the rejection scenario
        applyStimulus(1'b1, 4'd0, 1'b0, 4'd3);
        tick();
        checkOutput("seed0_lfsr", 32'(dut.lfsr), 32'd1);
        checkOutput("seed0_lfsr_b", 32'(dut_err.lfsr), 32'd1);

        applyStimulus(1'b0, 4'd0, 1'b1, 4'd3);
        tick();
        checkOutput("e1_busy_a", 32'(busy_a), 32'd1);
        checkOutput("e1_busy_b", 32'(busy_b), 32'd1);
        checkOutput("e1_valid_a", 32'(valid_a), 32'd0);
        q_a.push_back('{value: 4'd2, err: 1'b0});
        q_b.push_back('{value: 4'd0, err: 1'b1});
        applyStimulus(1'b0, 4'd0, 1'b0, 4'd3);
        for (int ed = 2; ed <= 20; ed++) begin
            tick();
            checkOutput($sformatf("busy_a_e%0d", ed), 32'(busy_a), 32'(ed < 13));
            if (valid_a) begin
                checkOutput("accept_edge", 32'(ed), 32'd13);
                popCheckA();
            end
            if (valid_b) begin
                checkOutput("error_edge", 32'(ed), 32'd5);
                popCheckB();
            end
        end
        checkOutput("q_a_drained", 32'(q_a.size()), 32'd0);
        checkOutput("q_b_drained", 32'(q_b.size()), 32'd0);
        checkOutput("random_a_held", 32'(random_a), 32'd2);
        checkOutput("err_b_held", 32'(err_b), 32'd1);
        checkOutput("valid_a_pulse", 32'(valid_a), 32'd0);

        // New request clears err, then a seed load aborts the search
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd3);
        tick();
        checkOutput("req_clears_err", 32'(err_b), 32'd0);
        checkOutput("req_busy_a", 32'(busy_a), 32'd1);
        applyStimulus(1'b1, 4'd9, 1'b0, 4'd3);
        tick();
        checkOutput("abort_busy_a", 32'(busy_a), 32'd0);
        checkOutput("abort_busy_b", 32'(busy_b), 32'd0);
        checkOutput("abort_valid_a", 32'(valid_a), 32'd0);
        checkOutput("abort_lfsr", 32'(dut.lfsr), 32'd9);
        applyStimulus(1'b0, 4'd9, 1'b0, 4'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abort_no_valid_a", 32'(valid_a), 32'd0);
            checkOutput("abort_no_valid_b", 32'(valid_b), 32'd0);
        end

        // Full range with req held high: a result every second edge
        applyStimulus(1'b1, 4'd5, 1'b0, 4'd0);
        tick();
        mlfsr = 4'd5;
        checkOutput("b2b_seed", 32'(dut.lfsr), 32'(mlfsr));
        applyStimulus(1'b0, 4'd5, 1'b1, 4'd0);
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 1) q_a.push_back('{value: mlfsr, err: 1'b0});
            tick();
            mlfsr = stepModel(mlfsr);
            checkOutput($sformatf("b2b_lfsr[%0d]", k), 32'(dut.lfsr), 32'(mlfsr));
            checkOutput($sformatf("b2b_valid[%0d]", k), 32'(valid_a), 32'(k % 2 == 1));
            if (valid_a) popCheckA();
        end
        applyStimulus(1'b0, 4'd5, 1'b0, 4'd0);
        checkOutput("b2b_drained", 32'(q_a.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
